fu_class_issue_arbiter: RTL and testbench
=========================================

Name: fu_class_issue_arbiter

Overview:
- Parametrised issue-stage arbiter; the generalised successor of the four-class ALU/LSU issue selector.
- Picks one functional-unit class per cycle by round-robin over NUM_CLASSES, then one ready unit within that class by per-class round-robin.
- Registers the decision and drives unit-select, wfid and class outputs to the execution units.
- Sits between the per-class wavefront pickers and the SIMD/SIMF/LSU/SALU execution units.

Parameters:
- NUM_CLASSES, 4, number of FU classes; index 0 = SALU, 1 = LSU, 2 = SIMF, 3 = SIMD (valid range 2..8).
- UNITS_PER_CLASS, 4, units per class; classes with fewer physical units tie unused ready bits to 0 (range 1..8).
- WF_ID_WIDTH, `WF_ID_LENGTH, width of a wavefront id.
- STARVE_LIMIT, 15, starvation threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- class_wf_valid  in  NUM_CLASSES  per-class picker has a candidate wavefront.
- class_wf_id  in  NUM_CLASSES*WF_ID_WIDTH  candidate wfid per class; class c occupies bits [c*W +: W].
- unit_ready  in  NUM_CLASSES*UNITS_PER_CLASS  per-unit ready; unit u of class c is bit c*U+u.
- class_ack  out  NUM_CLASSES  combinational one-hot; class granted this cycle (tells that picker to advance).
- issued_valid  out  1  registered; an issue occurred in the previous cycle.
- issued_wfid  out  WF_ID_WIDTH  registered wfid of the issued wavefront.
- issued_class  out  3  registered class index.
- unit_select  out  NUM_CLASSES*UNITS_PER_CLASS  registered one-hot unit select.

Behaviour:
- Class c is eligible when class_wf_valid[c]=1 AND at least one of its units has unit_ready=1 AND is not masked by the pending-select rule below.
- Class grant:
  - Round-robin starting at class_ptr+1 (mod NUM_CLASSES), searching ascending; the first eligible class wins.
  - class_ack is one-hot on a grant and all zero when no class is eligible.
- Unit grant: within the granted class, round-robin over its eligible units starting at unit_ptr[c]+1 (mod UNITS_PER_CLASS).
- Pointer updates, at the clock edge of a grant:
  - class_ptr <= granted class.
  - unit_ptr[granted class] <= granted unit.
  - All other pointers hold.
  - With no grant, all pointers hold.
- Latency:
  - Decision in cycle N; issued_valid, issued_wfid, issued_class and unit_select are presented in cycle N+1.
  - Every output is registered except class_ack.
- Pending-select mask: a unit whose unit_select bit is 1 in cycle N+1 is treated as not ready in cycle N+1, even if unit_ready is still 1. This prevents a double issue before the unit drops ready.
- No-grant cycle: next cycle issued_valid=0 and unit_select=0. issued_wfid and issued_class hold their last values.
- Reset (asynchronous assert, applies mid-operation too):
  - issued_valid=0, unit_select=0, issued_wfid=0, issued_class=0.
  - class_ptr=NUM_CLASSES-1 and every unit_ptr=UNITS_PER_CLASS-1, so class 0 / unit 0 has first priority.
  - class_ack is 0 while rst=0.
  - Any in-flight decision is discarded.
- Wrap-around: pointer NUM_CLASSES-1 makes the search start at class 0. The same rule applies to unit pointers.
- Single eligible class: it is granted every cycle, subject to the pending-select mask.
- Unit-ready changes take effect in the same cycle; there is no ready sampling delay.

Optional Feature:
- Macro: FU_ISSUE_STARVE_GUARD_EN.
- Defined:
  - Each class has a saturating wait counter (width clog2(STARVE_LIMIT+1)).
  - The counter increments in any cycle where the class is eligible but not granted, and clears on that class's grant or on reset.
  - Any class whose counter equals STARVE_LIMIT overrides round-robin; the lowest-index such class wins.
  - Pointers update normally on the grant.
- Undefined: counters are absent and arbitration is pure round-robin.

Decomposition:
- issue_definitions.h: class index constants (FU_CLASS_SALU=0, LSU=1, SIMF=2, SIMD=3) and the default STARVE_LIMIT.
- The WF_ID_LENGTH default is taken from global_definitions.h.
- One natural sub-module, rr_pick_onehot: a parametrised round-robin one-hot picker (request vector plus pointer in, one-hot grant plus index out).
  - Instantiated once for classes and NUM_CLASSES times for units.

Test Plan:
- Reset then all classes valid with all units ready -> class_ack 0001, 0010, 0100, 1000, 0001 on successive cycles; issued_class 0,1,2,3,0 one cycle later; issued_valid=1 every cycle.
- Class 3 valid only, unit_ready[15:12]=1111 held -> unit_select one-hot rotates 12,13,14,15,12; issued_wfid equals class_wf_id[3].
- Class 1 valid, one unit ready (bit 4) that drops ready 2 cycles after selection -> granted in cycle N, masked in N+1, not granted in N+1; no double issue.
- Class 2 valid but unit_ready[11:8]=0000 -> class_ack[2]=0 and issued_valid=0 for every cycle.
- rst pulled to 0 mid-stream (asynchronously, between edges) -> outputs zero immediately; after release, the first grant goes to class 0.
- With FU_ISSUE_STARVE_GUARD_EN and STARVE_LIMIT=2: class 0 continuously eligible, class 1 granted externally by pre-seeded pointers, class 0 counter reaches 2 -> class 0 granted on that cycle regardless of round-robin.

Source files
------------

// File: rtl/fu_class_issue_arbiter_pkg.sv
// rtl/fu_class_issue_arbiter_pkg.sv - shared constants for the FU class issue arbiter
//
// Purpose: FU class index constants, default widths/limits and a small index-width
//          helper shared by the arbiter and its round-robin picker.
// Ports:   none (package).
package fu_class_issue_arbiter_pkg;

  // Functional-unit class indices as seen on issued_class.
  localparam int FU_CLASS_SALU = 0;
  localparam int FU_CLASS_LSU  = 1;
  localparam int FU_CLASS_SIMF = 2;
  localparam int FU_CLASS_SIMD = 3;

  localparam int DEFAULT_STARVE_LIMIT = 15;

  // Default wavefront id width used across the issue stage.
  localparam int WF_ID_LENGTH = 6;

  // Width of an index into n items; a single item still needs one bit of storage.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_class_issue_arbiter_rr_pick_onehot.sv
// rtl/fu_class_issue_arbiter_rr_pick_onehot.sv - parametrised round-robin one-hot picker
//
// Purpose: grants the first requester found searching upward from ptr+1 (mod N).
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  last granted index; search starts just above it
//   grant out N   one-hot grant, all zero when nothing requests
//   idx   out IW  index of the granted requester (0 when no grant)
module rr_pick_onehot #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    int k;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    // Offsets 1..N visit every index once, ending at ptr itself.
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/fu_class_issue_arbiter.sv
// rtl/fu_class_issue_arbiter.sv - two-level round-robin FU class / unit issue arbiter
//
// Purpose: each cycle picks one eligible FU class by round-robin, then one ready unit
//          of that class by per-class round-robin, and registers the issue decision.
//          Optional starvation guard enabled by defining FU_ISSUE_STARVE_GUARD_EN.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   class_wf_valid in   NUM_CLASSES, per-class candidate present
//   class_wf_id    in   NUM_CLASSES*WF_ID_WIDTH, candidate wfid, class c at [c*W +: W]
//   unit_ready     in   NUM_CLASSES*UNITS_PER_CLASS, unit u of class c at bit c*U+u
//   class_ack      out  NUM_CLASSES, combinational one-hot class grant
//   issued_valid   out  registered, an issue happened last cycle
//   issued_wfid    out  WF_ID_WIDTH, registered wfid of last issue
//   issued_class   out  3, registered class index of last issue
//   unit_select    out  NUM_CLASSES*UNITS_PER_CLASS, registered one-hot unit select
module fu_class_issue_arbiter
  import fu_class_issue_arbiter_pkg::*;
#(
  parameter int NUM_CLASSES     = 4,
  parameter int UNITS_PER_CLASS = 4,
  parameter int WF_ID_WIDTH     = WF_ID_LENGTH,
  parameter int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLASSES-1:0]                 class_wf_valid,
  input  logic [NUM_CLASSES*WF_ID_WIDTH-1:0]     class_wf_id,
  input  logic [NUM_CLASSES*UNITS_PER_CLASS-1:0] unit_ready,
  output logic [NUM_CLASSES-1:0]                 class_ack,
  output logic                                   issued_valid,
  output logic [WF_ID_WIDTH-1:0]                 issued_wfid,
  output logic [2:0]                             issued_class,
  output logic [NUM_CLASSES*UNITS_PER_CLASS-1:0] unit_select
);

  localparam int CIW = idx_width(NUM_CLASSES);
  localparam int UIW = idx_width(UNITS_PER_CLASS);
  localparam int NU  = NUM_CLASSES * UNITS_PER_CLASS;

  logic [CIW-1:0]             class_ptr;
  logic [UIW-1:0]             unit_ptr  [NUM_CLASSES];
  logic [UNITS_PER_CLASS-1:0] unit_req  [NUM_CLASSES];
  logic [UNITS_PER_CLASS-1:0] unit_gnt  [NUM_CLASSES];
  logic [UIW-1:0]             unit_idx  [NUM_CLASSES];
  logic [NUM_CLASSES-1:0]     eligible;
  logic [NUM_CLASSES-1:0]     rr_gnt;
  logic [CIW-1:0]             rr_idx;
  logic [NUM_CLASSES-1:0]     class_gnt;
  logic [CIW-1:0]             class_idx;
  logic                       grant;
  logic [NU-1:0]              next_sel;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    // A unit selected last cycle may still show ready; mask it to avoid a double issue.
    assign unit_req[c] = unit_ready[c*UNITS_PER_CLASS +: UNITS_PER_CLASS]
                       & ~unit_select[c*UNITS_PER_CLASS +: UNITS_PER_CLASS];
    // Gating with rst keeps class_ack low for the whole reset assertion.
    assign eligible[c] = rst & class_wf_valid[c] & (|unit_req[c]);

    rr_pick_onehot #(.N(UNITS_PER_CLASS), .IW(UIW)) u_unit_pick (
      .req   (unit_req[c]),
      .ptr   (unit_ptr[c]),
      .grant (unit_gnt[c]),
      .idx   (unit_idx[c])
    );
  end

  rr_pick_onehot #(.N(NUM_CLASSES), .IW(CIW)) u_class_pick (
    .req   (eligible),
    .ptr   (class_ptr),
    .grant (rr_gnt),
    .idx   (rr_idx)
  );

`ifdef FU_ISSUE_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]          wait_cnt [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] starved;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_starve
    assign starved[c] = eligible[c] && (wait_cnt[c] == SW'(STARVE_LIMIT));
  end

  // A starved class beats round-robin; among several, the lowest index wins.
  always_comb begin
    logic found;
    class_gnt = rr_gnt;
    class_idx = rr_idx;
    found     = 1'b0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (!found && starved[c]) begin
        found     = 1'b1;
        class_gnt = NUM_CLASSES'(1) << c;
        class_idx = CIW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CLASSES; c++) wait_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (class_gnt[c])
          wait_cnt[c] <= '0;
        else if (eligible[c] && wait_cnt[c] != SW'(STARVE_LIMIT))
          wait_cnt[c] <= wait_cnt[c] + 1'b1;
      end
    end
  end
`else
  assign class_gnt = rr_gnt;
  assign class_idx = rr_idx;
`endif

  assign grant     = |class_gnt;
  assign class_ack = class_gnt;

  always_comb begin
    next_sel = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (class_gnt[c])
        next_sel[c*UNITS_PER_CLASS +: UNITS_PER_CLASS] = unit_gnt[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_valid <= 1'b0;
      issued_wfid  <= '0;
      issued_class <= '0;
      unit_select  <= '0;
      class_ptr    <= CIW'(NUM_CLASSES - 1);
      for (int c = 0; c < NUM_CLASSES; c++) unit_ptr[c] <= UIW'(UNITS_PER_CLASS - 1);
    end else begin
      issued_valid <= grant;
      unit_select  <= next_sel;
      if (grant) begin
        issued_wfid          <= class_wf_id[int'(class_idx)*WF_ID_WIDTH +: WF_ID_WIDTH];
        issued_class         <= 3'(class_idx);
        class_ptr            <= class_idx;
        unit_ptr[class_idx]  <= unit_idx[class_idx];
      end
    end
  end

endmodule

// File: tb/tb_fu_class_issue_arbiter.sv
// tb/tb_fu_class_issue_arbiter.sv - self-checking bench for fu_class_issue_arbiter
module tb_fu_class_issue_arbiter;

  localparam int NC = 4;
  localparam int U  = 4;
  localparam int W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     class_wf_valid;
  logic [NC*W-1:0]   class_wf_id;
  logic [NC*U-1:0]   unit_ready;
  logic [NC-1:0]     class_ack;
  logic              issued_valid;
  logic [W-1:0]      issued_wfid;
  logic [2:0]        issued_class;
  logic [NC*U-1:0]   unit_select;

  int passes = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fu_class_issue_arbiter #(
    .NUM_CLASSES(NC), .UNITS_PER_CLASS(U), .WF_ID_WIDTH(W), .STARVE_LIMIT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .class_wf_valid(class_wf_valid), .class_wf_id(class_wf_id), .unit_ready(unit_ready),
    .class_ack(class_ack), .issued_valid(issued_valid), .issued_wfid(issued_wfid),
    .issued_class(issued_class), .unit_select(unit_select)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pointers as plain integers, last-issued unit as a bit vector.
  int        m_cptr;
  int        m_uptr [NC];
  logic            m_valid;
  logic [NC*U-1:0] m_sel;
  logic [W-1:0]    m_wfid;
  logic [2:0]      m_class;
  bit d_any;
  int d_c, d_u;

  always @(negedge clk) begin : cmp
    int c, u, b;
    d_any = 1'b0; d_c = 0; d_u = 0;
    if (rst === 1'b1) begin
      for (int i = 1; i <= NC; i++) begin
        c = (m_cptr + i) % NC;
        if (!d_any && class_wf_valid[c]) begin
          for (int j = 1; j <= U; j++) begin
            u = (m_uptr[c] + j) % U;
            b = c * U + u;
            if (!d_any && unit_ready[b] && !m_sel[b]) begin
              d_any = 1'b1; d_c = c; d_u = u;
            end
          end
        end
      end
    end
    if (chk_en) begin
      chk("m_class_ack", 32'(class_ack), d_any ? (32'd1 << d_c) : 32'd0);
      chk("m_issued_valid", 32'(issued_valid), 32'(m_valid));
      chk("m_unit_select", 32'(unit_select), 32'(m_sel));
      chk("m_issued_wfid", 32'(issued_wfid), 32'(m_wfid));
      chk("m_issued_class", 32'(issued_class), 32'(m_class));
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cptr  <= NC - 1;
      for (int i = 0; i < NC; i++) m_uptr[i] <= U - 1;
      m_valid <= 1'b0; m_sel <= '0; m_wfid <= '0; m_class <= '0;
    end else begin
      m_valid <= d_any;
      if (d_any) begin
        m_sel        <= (NC*U)'(1) << (d_c * U + d_u);
        m_wfid       <= class_wf_id[d_c*W +: W];
        m_class      <= 3'(d_c);
        m_cptr       <= d_c;
        m_uptr[d_c]  <= d_u;
      end else begin
        m_sel <= '0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; class_wf_valid = '0; unit_ready = '0;
    mid(); cyc();
    rst = 1'b1;
  endtask

  logic [3:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  int          exp_cls [5] = '{0, 1, 2, 3, 0};
  logic [15:0] exp_us  [5] = '{16'h1000, 16'h2000, 16'h4000, 16'h8000, 16'h1000};
  logic [3:0]  pat_v   [6] = '{4'b1011, 4'b0110, 4'b1111, 4'b1001, 4'b0101, 4'b1110};
  logic [15:0] pat_r   [6] = '{16'h8421, 16'h0F30, 16'h1111, 16'hF00F, 16'h0303, 16'h7777};

  initial begin
    rst = 1'b0;
    class_wf_valid = '0;
    unit_ready = '0;
    class_wf_id = {6'h2A, 6'h15, 6'h0C, 6'h07};
    cyc();
    chk_en = 1'b1;
    chk("reset_issued_valid", 32'(issued_valid), 32'd0);
    chk("reset_unit_select", 32'(unit_select), 32'd0);
    chk("reset_class_ack", 32'(class_ack), 32'd0);

    // All classes valid, all units ready: class round-robin 0,1,2,3,0.
    rst = 1'b1; class_wf_valid = 4'hF; unit_ready = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (i < 5) chk("rr_class_ack", 32'(class_ack), 32'(exp_ack[i]));
      if (i >= 1) begin
        chk("rr_issued_class", 32'(issued_class), 32'(exp_cls[i-1]));
        chk("rr_issued_valid", 32'(issued_valid), 32'd1);
      end
      cyc();
    end

    // Only class 3: units 12,13,14,15,12 in turn.
    do_reset();
    class_wf_valid = 4'h8; unit_ready = 16'hF000;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (i < 5) chk("c3_class_ack", 32'(class_ack), 32'h8);
      if (i >= 1) begin
        chk("c3_unit_select", 32'(unit_select), 32'(exp_us[i-1]));
        chk("c3_issued_wfid", 32'(issued_wfid), 32'h2A);
      end
      cyc();
    end

    // Class 1 with one ready unit: pending-select mask blocks a second issue.
    do_reset();
    class_wf_valid = 4'h2; unit_ready = 16'h0010;
    mid(); chk("mask_first_ack", 32'(class_ack), 32'h2); cyc();
    mid();
    chk("mask_blocked_ack", 32'(class_ack), 32'h0);
    chk("mask_unit_select", 32'(unit_select), 32'h0010);
    cyc();
    unit_ready = 16'h0000;
    mid();
    chk("mask_no_double_valid", 32'(issued_valid), 32'd0);
    chk("mask_no_double_sel", 32'(unit_select), 32'd0);
    cyc();

    // Class 2 valid but none of its units ready: never granted.
    do_reset();
    class_wf_valid = 4'h4; unit_ready = 16'hF0FF;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("noready_ack", 32'(class_ack), 32'd0);
      chk("noready_valid", 32'(issued_valid), 32'd0);
      cyc();
    end

    // Asynchronous reset between edges mid-stream.
    do_reset();
    class_wf_valid = 4'hF; unit_ready = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin mid(); cyc(); end
    #2 rst = 1'b0;
    #1;
    chk("areset_valid", 32'(issued_valid), 32'd0);
    chk("areset_sel", 32'(unit_select), 32'd0);
    chk("areset_ack", 32'(class_ack), 32'd0);
    chk("areset_class", 32'(issued_class), 32'd0);
    chk("areset_wfid", 32'(issued_wfid), 32'd0);
    cyc();
    rst = 1'b1;
    mid(); chk("areset_first_ack", 32'(class_ack), 32'h1); cyc();
    mid();
    chk("areset_first_valid", 32'(issued_valid), 32'd1);
    chk("areset_first_sel", 32'(unit_select), 32'h0001);
    cyc();

    // Mixed directed patterns, checked by the model each cycle.
    for (int p = 0; p < 6; p++) begin
      class_wf_valid = pat_v[p]; unit_ready = pat_r[p];
      class_wf_id = {6'(p + 40), 6'(p + 30), 6'(p + 20), 6'(p + 10)};
      for (int k = 0; k < 3; k++) begin mid(); cyc(); end
    end
    class_wf_valid = '0; unit_ready = '0;
    mid(); cyc();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
